instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Owns the program counter (PC) and the instruction register (IR) for the multi-cycle vector processor.
- On request from the main control FSM's Fetch state, it performs one instruction-memory read using a req/ack handshake and latches the instruction.
- It presents the 8-bit opcode to the control unit and applies the control unit's pcWrite, pcWriteCond and pcSrc commands to update the PC.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- INSTR_W, 32, instruction width; opcode is instr[INSTR_W-1 -: 8].
- RESET_PC, 0, PC value after reset.
- WAIT_MAX, 15, maximum cycles to wait for imem_ack before aborting; must be >= 1.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- fetch_start  in  1  one-cycle pulse from control: begin fetch at the current PC.
- pcWrite  in  1  unconditional PC load.
- pcWriteCond  in  1  conditional PC load, qualified by zero.
- zero  in  1  ALU zero flag (branch condition).
- pcSrc  in  2  next-PC select: 0=alu_result, 1=alu_out, 2=jump target, 3=ra_value.
- alu_result  in  ADDR_W  combinational ALU output (PC+n).
- alu_out  in  ADDR_W  registered ALU output (branch target).
- ra_value  in  ADDR_W  return-address register contents (jr/rti).
- imem_req  out  1  read request; held high until ack.
- imem_addr  out  ADDR_W  read address.
- imem_rdata  in  INSTR_W  read data; valid while imem_ack=1.
- imem_ack  in  1  read complete.
- pc  out  ADDR_W  current PC.
- instr  out  INSTR_W  IR contents.
- op  out  8  instr[INSTR_W-1 -: 8], to the control unit.
- ir_valid  out  1  one-cycle pulse when a new IR value is available.
- fetch_err  out  1  one-cycle pulse on timeout.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, active-high; clock CLK):
  - pc=RESET_PC; instr=0 (so op=0); all other outputs 0; FSM=IDLE; wait counter=0.
  - Reset asserted mid-fetch drops imem_req immediately, with no wait for the clock edge.
- FSM states: IDLE, REQ, VALID.
  - IDLE: if fetch_start=1, capture fetch_addr<=pc, clear wait counter, go to REQ. Otherwise stay in IDLE.
  - REQ: imem_req=1, imem_addr=fetch_addr.
    - If imem_ack=1: instr<=imem_rdata, go to VALID.
    - Else if counter==WAIT_MAX-1: pulse fetch_err, leave instr unchanged, go to IDLE.
    - Else increment the counter.
  - VALID: ir_valid=1 for exactly this cycle, then go to IDLE.
- Latency: zero-wait memory (ack in the first REQ cycle) gives fetch_start at cycle N, imem_req at N+1, ir_valid at N+2. Each wait cycle adds 1.
- imem_req and imem_addr are registered/state-decoded and stable throughout REQ. imem_addr=0 outside REQ.
- imem_ack outside REQ is ignored.
- fetch_start while busy is ignored; there is no queuing.
- PC update is independent of the FSM and occurs every cycle:
  - Load enable: pc_en = pcWrite | (pcWriteCond & zero).
  - Jump target = instr[ADDR_W-1:0] (ADDR_W <= INSTR_W-8 required).
  - If pc_en, pc<=mux(pcSrc).
- A PC change during REQ does not disturb the in-flight read, because imem_addr uses fetch_addr.
- pcWrite and pcWriteCond both asserted: pcWrite dominates, and the PC loads regardless of zero.
- Address arithmetic is done externally; there is no wrap logic here, and PC values wrap naturally at 2^ADDR_W in the ALU.

Decomposition:
- Shared package vp_ctrl_pkg holds:
  - PCSRC_ALU=0, PCSRC_ALUOUT=1, PCSRC_JUMP=2, PCSRC_RA=3, shared with the control unit.
  - Fetch FSM state encodings (2-bit).
  - OP_W=8.
- One natural sub-module: pc_register, containing the next-PC mux plus the PC flop with the pc_en qualification.
- The FSM, wait counter and IR stay in the top module.

Test Plan:
- Reset then idle → pc=0, instr=0, op=0, imem_req=0, busy=0. Asserting Reset mid-REQ drops imem_req in the same cycle.
- pc=0x0010, fetch_start, ack on the first REQ cycle with rdata=0x1F000040 → imem_addr=0x0010, ir_valid 2 cycles after fetch_start, op=0x1F, instr=0x1F000040.
- Ack delayed 3 cycles → imem_req high for 4 cycles with addr constant; ir_valid 5 cycles after fetch_start; a fetch_start pulse during REQ is ignored.
- WAIT_MAX=4, no ack → fetch_err pulse on the 4th REQ cycle, return to IDLE, instr unchanged.
- PC writes:
  - pcWrite with pcSrc=0/1/3 and alu_result=0x0012, alu_out=0x0100, ra_value=0x0200 → pc loads each value in turn.
  - pcSrc=2 with instr=0x09001234 → pc=0x1234.
  - pcWriteCond=1 with zero=0 → pc unchanged; with zero=1 → pc loads.
- pcWrite with alu_result=0x0002 during REQ of a fetch from 0x0000 → imem_addr stays 0x0000 until ack; pc=0x0002 afterwards.

Source files
------------

// File: rtl/vp_ctrl_pkg.sv
// Constants shared between the control unit and the instruction fetch unit:
// next-PC source selects, fetch FSM state encodings and the opcode width.
package vp_ctrl_pkg;

  localparam int OP_W = 8;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RA     = 2'd3;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_VALID = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: req/ack handshake with address and read data.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter: next-PC select mux and the PC flop, loaded on
// pcWrite or on pcWriteCond qualified by the ALU zero flag.
module pc_register
  import vp_ctrl_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              pcWrite,
  input  logic              pcWriteCond,
  input  logic              zero,
  input  logic [1:0]        pcSrc,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [ADDR_W-1:0] jump,
  input  logic [ADDR_W-1:0] ra_value,
  output logic [ADDR_W-1:0] pc
);

  logic              pc_en;
  logic [ADDR_W-1:0] pc_next;

  // pcWrite dominates: with it set the branch condition is irrelevant.
  assign pc_en = pcWrite | (pcWriteCond & zero);

  always_comb begin
    pc_next = alu_result;
    case (pcSrc)
      PCSRC_ALU:    pc_next = alu_result;
      PCSRC_ALUOUT: pc_next = alu_out;
      PCSRC_JUMP:   pc_next = jump;
      PCSRC_RA:     pc_next = ra_value;
      default:      pc_next = alu_result;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)      pc <= RESET_PC;
    else if (pc_en) pc <= pc_next;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns PC and IR, runs one req/ack instruction read per
// fetch_start with a bounded wait, and presents the opcode to control.
module instr_fetch_unit
  import vp_ctrl_pkg::*;
#(
  parameter int               ADDR_W   = 16,
  parameter int               INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int               WAIT_MAX = 15
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                fetch_start,
  input  logic                pcWrite,
  input  logic                pcWriteCond,
  input  logic                zero,
  input  logic [1:0]          pcSrc,
  input  logic [ADDR_W-1:0]   alu_result,
  input  logic [ADDR_W-1:0]   alu_out,
  input  logic [ADDR_W-1:0]   ra_value,
  instr_fetch_unit_if.master  imem,
  output logic [ADDR_W-1:0]   pc,
  output logic [INSTR_W-1:0]  instr,
  output logic [OP_W-1:0]     op,
  output logic                ir_valid,
  output logic                fetch_err,
  output logic                busy
);

  localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr;
  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_done;

  assign wait_done = (wait_cnt == CNT_LAST);
  assign op        = instr[INSTR_W-1 -: OP_W];

  pc_register #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .CLK         (CLK),
    .Reset       (Reset),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .zero        (zero),
    .pcSrc       (pcSrc),
    .alu_result  (alu_result),
    .alu_out     (alu_out),
    .jump        (instr[ADDR_W-1:0]),
    .ra_value    (ra_value),
    .pc          (pc)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= FS_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_IDLE:  if (fetch_start) state_d = FS_REQ;
      FS_REQ: begin
        if (imem.imem_ack)  state_d = FS_VALID;
        else if (wait_done) state_d = FS_IDLE;
      end
      FS_VALID: state_d = FS_IDLE;
      default:  state_d = FS_IDLE;
    endcase
  end

  // Outputs decode from the registered state so imem_req falls as soon as
  // Reset forces the state back to IDLE.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = '0;
    ir_valid       = 1'b0;
    fetch_err      = 1'b0;
    busy           = (state_q != FS_IDLE);
    case (state_q)
      FS_REQ: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = fetch_addr;
        fetch_err      = ~imem.imem_ack & wait_done;
      end
      FS_VALID: ir_valid = 1'b1;
      default: ;
    endcase
  end

  // fetch_addr freezes the read address so PC writes during REQ are harmless.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fetch_addr <= '0;
      wait_cnt   <= '0;
      instr      <= '0;
    end else begin
      case (state_q)
        FS_IDLE: if (fetch_start) begin
          fetch_addr <= pc;
          wait_cnt   <= '0;
        end
        FS_REQ: begin
          if (imem.imem_ack)  instr    <= imem.imem_rdata;
          else if (!wait_done) wait_cnt <= wait_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected instructions are queued when
// a fetch is launched and popped when ir_valid fires.
module tb_instr_fetch_unit;
  import vp_ctrl_pkg::*;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              fetch_start, pcWrite, pcWriteCond, zero;
  logic [1:0]        pcSrc;
  logic [ADDR_W-1:0] alu_result, alu_out, ra_value;
  logic [ADDR_W-1:0] pc;
  logic [INSTR_W-1:0] instr;
  logic [7:0]        op;
  logic              ir_valid, fetch_err, busy;

  int errors = 0;
  int checks = 0;
  logic [INSTR_W-1:0] exp_q[$];
  logic [INSTR_W-1:0] exp_instr;
  logic [INSTR_W-1:0] last_instr;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (16'h0000),
    .WAIT_MAX (4)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .fetch_start (fetch_start),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .zero        (zero),
    .pcSrc       (pcSrc),
    .alu_result  (alu_result),
    .alu_out     (alu_out),
    .ra_value    (ra_value),
    .imem        (bus),
    .pc          (pc),
    .instr       (instr),
    .op          (op),
    .ir_valid    (ir_valid),
    .fetch_err   (fetch_err),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pc_load(input logic [1:0] src, input logic w, input logic wc, input logic z);
    pcSrc = src; pcWrite = w; pcWriteCond = wc; zero = z;
    tick();
    pcWrite = 1'b0; pcWriteCond = 1'b0; zero = 1'b0;
  endtask

  // Launch a fetch, ack after `delay` wait cycles, optionally pulse
  // fetch_start mid-REQ; checks req/addr each REQ cycle and ir_valid timing.
  task automatic do_fetch(input logic [ADDR_W-1:0] exp_addr, input logic [INSTR_W-1:0] data,
                          input int delay, input bit poke);
    fetch_start = 1'b1;
    exp_q.push_back(data);
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i <= delay; i++) begin
      chk("req_high", bus.imem_req, 1);
      chk("req_addr", bus.imem_addr, exp_addr);
      if (i == delay) begin
        bus.imem_ack = 1'b1; bus.imem_rdata = data;
      end else if (poke && i == 1) begin
        fetch_start = 1'b1;
      end
      tick();
      bus.imem_ack = 1'b0; fetch_start = 1'b0; bus.imem_rdata = $urandom;
    end
    chk("ir_valid", ir_valid, 1);
    exp_instr = exp_q.pop_front();
    chk("instr", instr, exp_instr);
    chk("op", op, {24'h0, exp_instr[31:24]});
    last_instr = exp_instr;
    tick();
    chk("ir_valid_drop", ir_valid, 0);
    chk("idle_after", busy, 0);
    chk("idle_req", bus.imem_req, 0);
  endtask

  initial begin
    Reset = 1'b1; fetch_start = 0; pcWrite = 0; pcWriteCond = 0; zero = 0;
    pcSrc = PCSRC_ALU; alu_result = '0; alu_out = '0; ra_value = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr, 0);
    chk("rst_op", op, 0);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irv", ir_valid, 0);
    chk("rst_err", fetch_err, 0);
    Reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // ack outside REQ must not change anything
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
    tick();
    bus.imem_ack = 1'b0;
    chk("stray_ack_instr", instr, 0);
    chk("stray_ack_busy", busy, 0);

    // zero-wait fetch from 0x0010
    alu_result = 16'h0010;
    pc_load(PCSRC_ALU, 1, 0, 0);
    chk("pc_0010", pc, 16'h0010);
    do_fetch(16'h0010, 32'h1F000040, 0, 0);

    // 3 wait cycles, with a fetch_start during REQ that must be ignored
    do_fetch(16'h0010, 32'h2A00BEEF, 3, 1);

    // PC source select
    alu_result = 16'h0012; alu_out = 16'h0100; ra_value = 16'h0200;
    pc_load(PCSRC_ALU, 1, 0, 0);    chk("pc_alu", pc, 16'h0012);
    pc_load(PCSRC_ALUOUT, 1, 0, 0); chk("pc_aluout", pc, 16'h0100);
    pc_load(PCSRC_RA, 1, 0, 0);     chk("pc_ra", pc, 16'h0200);

    do_fetch(16'h0200, 32'h09001234, 0, 0);
    pc_load(PCSRC_JUMP, 1, 0, 0);   chk("pc_jump", pc, 16'h1234);

    alu_result = 16'h0055;
    pc_load(PCSRC_ALU, 0, 1, 0);    chk("pc_cond_nz", pc, 16'h1234);
    pc_load(PCSRC_ALU, 0, 1, 1);    chk("pc_cond_z", pc, 16'h0055);
    alu_result = 16'h0077;
    pc_load(PCSRC_ALU, 1, 1, 0);    chk("pc_both", pc, 16'h0077);
    pc_load(PCSRC_ALU, 0, 0, 1);    chk("pc_noen", pc, 16'h0077);

    // timeout: WAIT_MAX=4, err pulse on the 4th REQ cycle
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", bus.imem_req, 1);
      chk("to_addr", bus.imem_addr, 16'h0077);
      chk("to_err", fetch_err, (i == 3) ? 1 : 0);
      tick();
    end
    chk("to_idle", busy, 0);
    chk("to_err_drop", fetch_err, 0);
    chk("to_irv", ir_valid, 0);
    chk("to_instr", instr, last_instr);

    // PC write during REQ leaves the in-flight address alone
    alu_result = 16'h0000;
    pc_load(PCSRC_ALU, 1, 0, 0);
    fetch_start = 1'b1;
    exp_q.push_back(32'h3C00ABCD);
    tick();
    fetch_start = 1'b0;
    alu_result = 16'h0002; pcWrite = 1'b1;
    chk("mid_addr0", bus.imem_addr, 16'h0000);
    tick();
    pcWrite = 1'b0;
    chk("mid_pc", pc, 16'h0002);
    chk("mid_addr1", bus.imem_addr, 16'h0000);
    chk("mid_req", bus.imem_req, 1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3C00ABCD;
    tick();
    bus.imem_ack = 1'b0;
    chk("mid_irv", ir_valid, 1);
    exp_instr = exp_q.pop_front();
    chk("mid_instr", instr, exp_instr);
    chk("mid_pc_after", pc, 16'h0002);
    tick();

    // async reset mid-REQ drops imem_req before the next edge
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    chk("ar_req_pre", bus.imem_req, 1);
    #2 Reset = 1'b1;
    #1;
    chk("ar_req", bus.imem_req, 0);
    chk("ar_busy", busy, 0);
    chk("ar_pc", pc, 0);
    chk("ar_instr", instr, 0);
    tick();
    Reset = 1'b0;
    tick();
    chk("ar_idle", busy, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
